// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer: prescaled tick, rippled mod-10 digit chain,
// IDLE/RUN/PAUSE control and a lap-freeze display path.
module bcd_stopwatch_ctrl #(
  parameter int PRESCALE = 10,
  parameter int NDIGITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_stop,
  input  logic                 clear,
  input  logic                 lap,
  output logic [4*NDIGITS-1:0] count,
  output logic [4*NDIGITS-1:0] display,
  output logic                 tick,
  output logic                 running,
  output logic                 lap_active,
  output logic                 overflow,
  output logic                 carry
);

  localparam int PW = $clog2(PRESCALE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [1:0]           state;
  logic [PW-1:0]        psc;
  logic [4*NDIGITS-1:0] lap_reg;
  logic [NDIGITS-1:0]   nines_below;

  // nines_below[k] is set when every digit below k reads 9, i.e. digit k may advance.
  always_comb begin
    logic acc;
    acc         = 1'b1;
    nines_below = '0;
    for (int k = 0; k < NDIGITS; k++) begin
      nines_below[k] = acc;
      acc            = acc & (count[4*k +: 4] == 4'd9);
    end
    carry = acc;
  end

  assign running = (state == S_RUN);
  assign display = lap_active ? lap_reg : count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      psc        <= '0;
      tick       <= 1'b0;
      count      <= '0;
      lap_reg    <= '0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      state      <= S_IDLE;
      psc        <= '0;
      tick       <= 1'b0;
      count      <= '0;
      lap_reg    <= '0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      tick <= 1'b0;
      // The prescaler does not advance on the cycle that pauses, so the phase resumes intact.
      if (state == S_RUN && !start_stop) begin
        if (psc == PW'(PRESCALE - 1)) begin
          psc  <= '0;
          tick <= 1'b1;
        end else begin
          psc <= psc + 1'b1;
        end
      end

      if (tick) begin
        for (int k = 0; k < NDIGITS; k++) begin
          if (nines_below[k]) begin
            count[4*k +: 4] <= (count[4*k +: 4] == 4'd9) ? 4'd0 : count[4*k +: 4] + 4'd1;
          end
        end
        if (carry) begin
          overflow <= 1'b1;
        end
      end

      if (start_stop) begin
        state <= (state == S_RUN) ? S_PAUSE : S_RUN;
      end

      if (lap && state != S_IDLE) begin
        if (!lap_active) begin
          lap_reg <= count;
        end
        lap_active <= !lap_active;
      end
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Randomised and directed bench for bcd_stopwatch_ctrl against a decimal-arithmetic model.
module tb_bcd_stopwatch_ctrl;

  localparam int PRESCALE = 4;
  localparam int NDIGITS  = 2;
  localparam int MAXV     = 100;
  localparam int W        = 4 * NDIGITS;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_stop = 1'b0;
  logic         clear = 1'b0;
  logic         lap = 1'b0;
  logic [W-1:0] count;
  logic [W-1:0] display;
  logic         tick;
  logic         running;
  logic         lap_active;
  logic         overflow;
  logic         carry;

  int tests_run    = 0;
  int tests_failed = 0;

  int m_state = M_IDLE;
  int m_phase = 0;
  int m_count = 0;
  int m_lap   = 0;
  bit m_tick  = 1'b0;
  bit m_lapact = 1'b0;
  bit m_ovf   = 1'b0;

  bcd_stopwatch_ctrl #(.PRESCALE(PRESCALE), .NDIGITS(NDIGITS)) dut (
    .clk(clk),
    .rst(rst),
    .start_stop(start_stop),
    .clear(clear),
    .lap(lap),
    .count(count),
    .display(display),
    .tick(tick),
    .running(running),
    .lap_active(lap_active),
    .overflow(overflow),
    .carry(carry)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    int t;
    logic [W-1:0] r;
    t = v;
    r = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string tag);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL timeout_%s: got no event expected event", tag);
  endtask

  task automatic modelStep(input bit r, input bit ss, input bit cl, input bit lp);
    bit nt;
    int nc;
    if (!r || cl) begin
      m_state  = M_IDLE;
      m_phase  = 0;
      m_tick   = 1'b0;
      m_count  = 0;
      m_lap    = 0;
      m_lapact = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      nt = 1'b0;
      nc = m_count;
      if (m_state == M_RUN && !ss) begin
        m_phase++;
        if (m_phase == PRESCALE) begin
          m_phase = 0;
          nt = 1'b1;
        end
      end
      if (m_tick) begin
        if (m_count == MAXV - 1) m_ovf = 1'b1;
        nc = (m_count + 1) % MAXV;
      end
      if (lp && m_state != M_IDLE) begin
        if (!m_lapact) m_lap = m_count;
        m_lapact = !m_lapact;
      end
      if (ss) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
      m_count = nc;
      m_tick  = nt;
    end
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, compare just after.
  task automatic applyStimulus(input bit r, input bit ss, input bit cl, input bit lp);
    @(negedge clk);
    rst        = r;
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    @(posedge clk);
    modelStep(r, ss, cl, lp);
    #1;
    checkOutput("count", count, to_bcd(m_count));
    checkOutput("display", display, m_lapact ? to_bcd(m_lap) : to_bcd(m_count));
    checkOutput("tick", tick, m_tick);
    checkOutput("running", running, m_state == M_RUN);
    checkOutput("lap_active", lap_active, m_lapact);
    checkOutput("overflow", overflow, m_ovf);
    checkOutput("carry", carry, m_count == MAXV - 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic runUntilCount(input int target, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      if (m_count == target) hit = 1'b1;
      else idle(1);
    end
    if (!hit) reportTimeout(tag);
  endtask

  initial begin
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_running", running, 0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("start_running", running, 1);
    idle(3);
    checkOutput("no_early_tick", tick, 0);
    idle(1);
    checkOutput("first_tick", tick, 1);
    idle(1);
    checkOutput("first_count", count, 8'h01);
    idle(8);

    // Pause with the prescaler at 2, hold, and resume.
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
        if (m_state == M_RUN && m_phase == 2) hit = 1'b1;
        else idle(1);
      end
      if (!hit) reportTimeout("pause_phase");
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    checkOutput("resume_no_tick", tick, 0);
    idle(1);
    checkOutput("resume_tick", tick, 1);

    runUntilCount(99, "reach_99");
    checkOutput("carry_at_99", carry, 1);
    runUntilCount(0, "wrap");
    checkOutput("overflow_set", overflow, 1);
    idle(10);
    checkOutput("overflow_sticky", overflow, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("clear_overflow", overflow, 0);
    checkOutput("clear_running", running, 0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    runUntilCount(37, "reach_37");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runUntilCount(45, "reach_45");
    checkOutput("lap_hold", display, 8'h37);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("lap_release", lap_active, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("lap_idle", lap_active, 0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    idle(9);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("prio_running", running, 0);
    checkOutput("prio_count", count, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    idle(10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("rst_prio_lap", lap_active, 0);
    checkOutput("rst_prio_count", count, 0);

    // Lap on the same edge that consumes a tick.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
        if (m_tick && m_count == 19) hit = 1'b1;
        else idle(1);
      end
      if (!hit) reportTimeout("tick_at_19");
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("coinc_display", display, 8'h19);
    checkOutput("coinc_count", count, 8'h20);

    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(199) != 0,
                    $urandom_range(14) == 0,
                    $urandom_range(299) == 0,
                    $urandom_range(11) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
Name: bcd_stopwatch_ctrl

Overview:
Controller and sequencer for a chain of decimal (BCD) digit counters forming a stopwatch/event timer.
- Derives a count tick from the system clock through a programmable prescaler.
- Ripples enables across NDIGITS mod-10 digits.
- Runs an IDLE/RUN/PAUSE state machine driven by start/stop, clear and lap pulses.
- Provides a lap-freeze display path.
- Sits between debounced push-button pulse logic and the 7-segment display multiplexer.

Parameters:
PRESCALE, 10, clock cycles per count tick (>=2)
NDIGITS, 4, number of BCD digits in the chain (1..8)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, ACTIVE-LOW (0 = reset on next clk edge)
start_stop  input  1  one-cycle pulse, toggles run/pause
clear  input  1  one-cycle pulse, zero everything and return to IDLE
lap  input  1  one-cycle pulse, toggles display freeze
count  output  4*NDIGITS  live BCD count, digit 0 in bits [3:0]
display  output  4*NDIGITS  count, or frozen lap value when lap_active=1
tick  output  1  one-cycle prescaler tick (only in RUN)
running  output  1  1 when state == RUN
lap_active  output  1  1 while display is frozen
overflow  output  1  sticky, set when full-scale count wraps to zero
carry  output  1  combinational, 1 when all digits == 9

Behaviour:
Reset
- rst=0 at a clk edge: state=IDLE; prescaler=0; count=0; lap register=0; lap_active=0; overflow=0; tick=0.
- Reset has priority over every other input.

State machine
- States IDLE, RUN, PAUSE; encoding is free.
- start_stop: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
- clear from any state: ->IDLE; zeroes count, prescaler, overflow, lap_active.
- Priority in the same cycle: rst > clear > start_stop/lap.
- start_stop and lap asserted in the same cycle are both honoured.
- running is registered and goes high on the same edge that samples start_stop.

Prescaler
- Counts 0..PRESCALE-1 only in RUN.
- Holds its value in PAUSE, so no partial period is lost. Zeroed in IDLE.
- tick=1 (registered) for exactly one cycle when the prescaler wraps from PRESCALE-1 to 0.
- From IDLE with start_stop at edge N: first tick is high after edge N+PRESCALE.

Digit chain
- Digit 0 increments on the edge following tick=1.
- Digit k increments on that edge only if digits 0..k-1 are all 9.
- Each digit rolls 9->0; values 10..15 never occur.
- All digits 9 at a tick: count wraps to 0, overflow set to 1. overflow clears only on clear or rst.
- carry = AND over digits of (digit == 9); purely combinational.

Lap
- Honoured in RUN and PAUSE; ignored in IDLE.
- lap with lap_active=0: lap register captures the current count (pre-increment value if tick is coincident) and lap_active goes to 1.
- lap with lap_active=1: lap_active goes to 0.
- display = lap_active ? lap register : count. Combinational mux from registers.

Inputs
- Each high cycle of start_stop/lap/clear is one event; upstream guarantees single-cycle pulses.

Test Plan:
(All with PRESCALE=4, NDIGITS=2.)
1. Reset/start. rst=0 for 2 cycles, then start_stop at edge 0 -> running=1 after edge 0; tick high after edges 4, 8, 12; count = 0x01, 0x02, 0x03 one edge after each tick; outputs all 0 during reset.
2. Pause preserves phase. Pause with prescaler=2, wait 20 cycles, resume -> count frozen during pause; next tick exactly 2 cycles after resume.
3. Wrap/overflow. Run to count=0x99 -> carry=1; next tick -> count=0x00, overflow=1 and stays 1; a further clear -> overflow=0, state IDLE.
4. Lap. lap at count=0x37 in RUN -> display holds 0x37 while count advances to 0x45; second lap -> display=count next cycle; lap in IDLE -> no change.
5. Priorities. clear and start_stop in the same cycle in PAUSE -> IDLE, count=0, running=0. rst=0 coincident with clear and lap -> full reset values.
6. Coincident lap and tick at count=0x19 -> lap register=0x19, count=0x20.
